// File: rtl/cmp_sched_pkg.sv
// Shared types and the round-robin pick helper for the cmp_sched comparator scheduler.
package cmp_sched_pkg;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IDW  = 3;

    typedef enum logic [2:0] {
        LE   = 3'd0,
        LT   = 3'd1,
        GE   = 3'd2,
        GT   = 3'd3,
        EQ   = 3'd4,
        NE   = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping at nreq.
    function automatic logic [MAX_IDW:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                 input logic [MAX_IDW-1:0]  ptr,
                                                 input int unsigned         nreq);
        logic [MAX_IDW:0] pick;
        logic             found;
        int unsigned      k;
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_NREQ; off++) begin
            k = 32'(ptr) + off;
            if (k >= nreq) begin
                k = k - nreq;
            end
            if ((off < nreq) && !found && valid[k[MAX_IDW-1:0]]) begin
                found = 1'b1;
                pick  = {1'b1, k[MAX_IDW-1:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned magnitude/equality comparator; reserved opcodes flag err.
module cmp_unit
    import cmp_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  cmp_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             result_o,
    output logic             err_o
);

    always_comb begin
        result_o = 1'b0;
        err_o    = 1'b0;
        unique case (op_i)
            LE:      result_o = (a_i <= b_i);
            LT:      result_o = (a_i <  b_i);
            GE:      result_o = (a_i >= b_i);
            GT:      result_o = (a_i >  b_i);
            EQ:      result_o = (a_i == b_i);
            NE:      result_o = (a_i != b_i);
            default: err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one comparator among NREQ requesters; one compare in flight.
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    cmp_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_result_q, rsp_result_d;
    logic             rsp_err_q, rsp_err_d;

    logic [MAX_IDW:0]   pick;
    logic               pick_vld;
    logic [MAX_IDW-1:0] pick_idx;
    logic               cu_result;
    logic               cu_err;

    assign pick     = rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(rr_ptr_q), NREQ);
    assign pick_vld = pick[MAX_IDW];
    assign pick_idx = pick[MAX_IDW-1:0];

    cmp_unit #(.WIDTH(WIDTH)) u_cmp_unit (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (cu_result),
        .err_o    (cu_err)
    );

    // Grant strobe is only offered while idle.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && pick_vld) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                req_ready[i] = (pick_idx == MAX_IDW'(i));
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (pick_idx == MAX_IDW'(i)) begin
                            op_d = cmp_op_e'(req_op[i*3 +: 3]);
                            a_d  = req_a[i*WIDTH +: WIDTH];
                            b_d  = req_b[i*WIDTH +: WIDTH];
                            id_d = IDW'(i);
                        end
                    end
                    state_d = CMP;
                end
            end
            CMP: begin
                rsp_result_d = cu_result;
                rsp_err_d    = cu_err;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_q         <= LE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_sched.sv
// Directed self-checking bench for cmp_sched with hand-computed expectations.
module tb_cmp_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_result;
    logic                  rsp_err;
    logic                  busy;

    int errors = 0;
    int checks = 0;

    cmp_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[idx*3 +: 3]       = op;
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    // One isolated transaction from IDLE, rsp_ready held high; returns in IDLE.
    task automatic run_one(input string tag, input int idx, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic exp_res, input logic exp_err);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        set_req(idx, op, a, b);
        req_valid = onehot;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        tick();
        req_valid = '0;
        set_req(idx, ~op, ~a, ~b);
        chk({tag, "_cmp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_cmp_busy"}, 32'(busy), 1);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
        chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        tick();
        chk({tag, "_drop"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        logic [3:0] exp_rdy;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_result", 32'(rsp_result), 0);
        chk("rst_err", 32'(rsp_err), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(req_ready), 0);

        run_one("single", 2, 3'd2, 4'b1010, 4'b0101, 1'b1, 1'b0);

        run_one("rsv6", 1, 3'd6, 4'hF, 4'h0, 1'b0, 1'b1);
        run_one("rsv7", 2, 3'd7, 4'h3, 4'h3, 1'b0, 1'b1);
        run_one("clr_err", 0, 3'd3, 4'hF, 4'h0, 1'b1, 1'b0);

        run_one("le_eq", 0, 3'd0, 4'b1010, 4'b1010, 1'b1, 1'b0);
        run_one("lt_eq", 1, 3'd1, 4'b1010, 4'b1010, 1'b0, 1'b0);
        run_one("ge_eq", 2, 3'd2, 4'b1010, 4'b1010, 1'b1, 1'b0);
        run_one("gt_eq", 3, 3'd3, 4'b1010, 4'b1010, 1'b0, 1'b0);
        run_one("eq_eq", 0, 3'd4, 4'b1010, 4'b1010, 1'b1, 1'b0);
        run_one("ne_eq", 1, 3'd5, 4'b1010, 4'b1010, 1'b0, 1'b0);
        run_one("lt_gt", 2, 3'd1, 4'h3, 4'hC, 1'b1, 1'b0);
        run_one("ge_zero", 0, 3'd2, 4'h0, 4'h0, 1'b1, 1'b0);
        run_one("lt_zero", 3, 3'd1, 4'h0, 4'h0, 1'b0, 1'b0);

        // Pointer is back at 0; all requesters valid, op LT with a=i, b=2.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 3'd1, 4'(i), 4'd2);
        end
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c <= 12; c++) begin
            exp_rdy = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
            if (c % 3 == 2) begin
                chk($sformatf("rr_id_c%0d", c), 32'(rsp_id), 32'((c / 3) % 4));
                chk($sformatf("rr_res_c%0d", c), 32'(rsp_result), ((c / 3) % 4 < 2) ? 1 : 0);
            end
            if (c < 12) tick();
        end

        // Backpressure on the second grant of requester 0.
        tick();
        rsp_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("bp_id_%0d", k), 32'(rsp_id), 0);
            chk($sformatf("bp_res_%0d", k), 32'(rsp_result), 1);
            chk($sformatf("bp_busy_%0d", k), 32'(busy), 1);
            chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 32'(rsp_valid), 1);
        chk("bp_hs_ready", 32'(req_ready), 0);
        tick();
        chk("bp_next_ready", 32'(req_ready), 32'(4'b0010));
        chk("bp_next_valid", 32'(rsp_valid), 0);
        tick();
        req_valid = '0;
        tick();
        chk("bp_next_id", 32'(rsp_id), 1);
        chk("bp_next_res", 32'(rsp_result), 1);
        tick();

        run_one("pre_rst", 2, 3'd4, 4'h7, 4'h7, 1'b1, 1'b0);

        // Pointer now 3; abandon a transaction in CMP.
        set_req(2, 3'd0, 4'h1, 4'h2);
        req_valid = 4'b0100;
        #1;
        chk("mid_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = '0;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_valid", 32'(rsp_valid), 0);
        set_req(1, 3'd3, 4'h9, 4'h4);
        set_req(3, 3'd1, 4'h9, 4'h4);
        req_valid = 4'b1010;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        tick();
        chk("post_rst_id", 32'(rsp_id), 1);
        chk("post_rst_res", 32'(rsp_result), 1);
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
Shares one unsigned magnitude/equality comparator between NREQ requesters. Each requester issues a compare transaction of the form (op, a, b). The block arbitrates round-robin, runs one comparison at a time through the shared comparator, and returns a 1-bit result tagged with the requester id. It sits between control-path clients (threshold monitors, limit checkers) and the comparator datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand width in bits
IDW, $clog2(NREQ), requester id width (derived; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept strobe, one-hot or zero
req_op  in  NREQ*3  per-requester opcode, requester i at bits [3i+2:3i]
req_a  in  NREQ*WIDTH  per-requester left operand
req_b  in  NREQ*WIDTH  per-requester right operand
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  id of the requester being answered
rsp_result  out  1  comparison result
rsp_err  out  1  reserved opcode was used
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, req_ready=0.
- Opcodes (all unsigned): 0 LE, 1 LT, 2 GE, 3 GT, 4 EQ, 5 NE. Opcodes 6 and 7 give result=0 and err=1.
- FSM has three states: IDLE, CMP, RESP.
- IDLE:
  - req_ready is combinational and equals the one-hot grant.
  - The grant goes to the first requester i with req_valid[i]=1, scanning from rr_ptr upward and wrapping NREQ-1 to 0.
  - On grant, latch op, a, b and id, then go to CMP.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- CMP:
  - The sub-module evaluates the latched operands.
  - Register the result and err into rsp_result and rsp_err, and the latched id into rsp_id.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_result and rsp_err stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid goes to 0 next cycle, rr_ptr becomes (grant+1) mod NREQ, and the FSM returns to IDLE.
- Timing:
  - Accept in cycle T gives rsp_valid at T+2.
  - Minimum spacing between accepts is 3 cycles when rsp_ready is held at 1.
- Requests are sampled only in IDLE. req_valid and operands of non-granted requesters are ignored in CMP and RESP.
- A granted requester may drop or change its inputs after its req_ready cycle; the latched values are used.
- rsp_ready=1 while not in RESP has no effect.
- rsp_ready is allowed to be held high permanently.
- Fairness: with all requesters permanently valid, the grant order is 0,1,...,NREQ-1,0,...
- A requester asserting valid in the same cycle as the RESP handshake is eligible in the following IDLE cycle.
- Reset asserted mid-transaction abandons the transaction immediately: no response is produced and rr_ptr returns to 0.
- Operand widths: a and b are WIDTH bits and are never extended or truncated. Comparisons against 0 follow plain unsigned rules:
  - a<0 is always 0.
  - a>=0 is always 1.

Decomposition:
- Package cmp_sched_pkg holds:
  - the cmp_op_e enum (3-bit) with values LE, LT, GE, GT, EQ, NE, RSV6, RSV7
  - the state_e enum with values IDLE, CMP, RESP
- Sub-module cmp_unit is purely combinational, parameterised by WIDTH. Inputs: op, a, b. Outputs: result, err.
- The round-robin pick is a function in the package, not a separate module.

Test Plan:
- Single request: requester 2 sends op=GE, a=4'b1010, b=4'b0101 in cycle 0, rsp_ready=1 → req_ready=4'b0100 in cycle 0; rsp_valid in cycle 2 with rsp_id=2, rsp_result=1, rsp_err=0.
- Opcode sweep: a=4'b1010, b=4'b1010 for ops 0..5 → results 1,0,1,0,1,0. Then a=0, b=0 for op LT → 0.
- Round-robin: all four requesters valid continuously, rsp_ready=1 → grants 0,1,2,3,0 on accept cycles 0,3,6,9,12.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_id and rsp_result stay stable, busy=1, and no req_ready pulses. When rsp_ready rises, the next accept occurs 1 cycle after the handshake.
- Reserved opcode: op=6, a=4'hF, b=4'h0 → rsp_result=0, rsp_err=1. The next legal request clears rsp_err.
- Reset mid-op: assert rst_n=0 while in CMP → rsp_valid=0 and busy=0 immediately. After release, requesters 1 and 3 both valid → requester 1 is granted first (rr_ptr=0).
